hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1..3: cycles flush_id stays asserted per taken branch.
REQ-002 Parameter TIMEOUT, default 255, range 1..255: maximum memory-wait cycles before error.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 Rs1_ID, Rs2_ID  input  5 each  source register indices of the instruction in ID.
REQ-006 rs1_used_ID, rs2_used_ID  input  1 each  the ID instruction reads Rs1 / Rs2.
REQ-007 Rd_EX  input  5  destination index of the instruction in EX.
REQ-008 d_load_enable_EX  input  1  the EX instruction is a load.
REQ-009 pc_taken_EX  input  1  jump/branch taken in EX.
REQ-010 d_req_MEM  input  1  the MEM instruction accesses data memory.
REQ-011 d_ready  input  1  data memory ack; the access completes in a cycle with d_req_MEM=1 and d_ready=1.
REQ-012 cnt_clr  input  1  synchronous clear of the performance counters.
REQ-013 stall_pc  output  1  hold PC and the IF/ID register.
REQ-014 stall_id  output  1  hold the ID/EX inputs (the decoder keeps its instruction).
REQ-015 stall_exmem  output  1  hold the EX/MEM and MEM/WB registers.
REQ-016 bubble_ex  output  1  load zeros (NOP) into ID/EX.
REQ-017 flush_id  output  1  nullify the ID instruction; drives the ID-stage nullify input.
REQ-018 state  output  2  current state: RUN=0, LU=1, FLUSH=2, MWAIT=3.
REQ-019 mem_timeout  output  1  sticky error flag.
REQ-020 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-021 mem_hold SHALL equal d_req_MEM & ~d_ready.
REQ-022 load_use SHALL equal d_load_enable_EX & (Rd_EX != 0) & ((rs1_used_ID & Rs1_ID==Rd_EX) | (rs2_used_ID & Rs2_ID==Rd_EX)).
REQ-023 Priority SHALL be mem_hold > pc_taken_EX > load_use, evaluated combinationally every cycle.
REQ-024 Any state, mem_hold=1: stall_pc=stall_id=stall_exmem=1, bubble_ex=flush_id=0, next state MWAIT.
REQ-025 MWAIT SHALL exit when d_ready=1, returning to the state held on entry (RUN, or FLUSH with the remaining flush count preserved).
REQ-026 A wait counter SHALL count consecutive mem_hold cycles; on reaching TIMEOUT, mem_timeout SHALL set and hold until reset; stalling continues.
REQ-027 RUN, pc_taken_EX=1, no mem_hold: flush_id=1 that cycle; if FLUSH_CYCLES>1, next state FLUSH, otherwise stay in RUN.
REQ-028 FLUSH SHALL keep flush_id=1 until FLUSH_CYCLES total flush cycles have elapsed, then return to RUN.
REQ-029 load_use SHALL be ignored while flush_id=1.
REQ-030 pc_taken_EX in FLUSH SHALL restart the flush count.
REQ-031 RUN, load_use=1, no higher-priority event: stall_pc=stall_id=bubble_ex=1 for exactly one cycle, next state LU.
REQ-032 LU SHALL ignore load_use, drive all stalls low, and return to RUN next cycle, unless mem_hold or pc_taken_EX applies.
REQ-033 Rd_EX=0 SHALL never produce load_use.
REQ-034 stall_cnt SHALL increment each cycle with stall_pc=1.
REQ-035 flush_cnt SHALL increment once per accepted pc_taken_EX cycle.
REQ-036 Both counters SHALL saturate at 0xFFFF.
REQ-037 cnt_clr SHALL zero both counters next edge, overriding an increment in the same cycle.
REQ-038 All outputs not asserted by a rule above SHALL be 0.

Reset
REQ-039 reset_n=0 at an edge SHALL set state=RUN and clear the wait counter, flush count, counters and mem_timeout, regardless of the current state.
REQ-040 While reset_n=0, all stall, bubble and flush outputs SHALL be 0.
REQ-041 The first edge with reset_n=1 SHALL resume normal operation.

Verification
REQ-042 Load-use: Rd_EX=5, load=1, Rs2_ID=5, rs2_used=1 -> one cycle of stall_pc/stall_id/bubble_ex=1, state LU, then RUN; stall_cnt=1.
REQ-043 Rd_EX=0 with a load and Rs1_ID=0 used -> no stall.
REQ-044 FLUSH_CYCLES=2, pc_taken_EX 1 cycle -> flush_id high 2 cycles, flush_cnt=1; a simultaneous load_use produces no bubble.
REQ-045 d_req_MEM=1, d_ready=0 for 3 cycles during a load_use -> only memory stalls for 3 cycles, bubble_ex=0, then the load-use bubble.
REQ-046 TIMEOUT=4, d_ready held 0 -> mem_timeout=1 after the 4th wait cycle, sticky after d_ready=1, cleared only by reset.
REQ-047 stall_cnt preloaded near 0xFFFF via long waits -> saturates; cnt_clr with a stall in the same cycle -> 0; reset in MWAIT -> RUN, outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: pipeline status in, stall/flush controls out.
// The pipeline side is the master; the hazard controller is the slave.
interface hazard_ctrl_if;
  logic [4:0]  Rs1_ID;
  logic [4:0]  Rs2_ID;
  logic        rs1_used_ID;
  logic        rs2_used_ID;
  logic [4:0]  Rd_EX;
  logic        d_load_enable_EX;
  logic        pc_taken_EX;
  logic        d_req_MEM;
  logic        d_ready;
  logic        cnt_clr;

  logic        stall_pc;
  logic        stall_id;
  logic        stall_exmem;
  logic        bubble_ex;
  logic        flush_id;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output Rs1_ID, Rs2_ID, rs1_used_ID, rs2_used_ID, Rd_EX, d_load_enable_EX,
           pc_taken_EX, d_req_MEM, d_ready, cnt_clr,
    input  stall_pc, stall_id, stall_exmem, bubble_ex, flush_id, state,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_ID, Rs2_ID, rs1_used_ID, rs2_used_ID, Rd_EX, d_load_enable_EX,
           pc_taken_EX, d_req_MEM, d_ready, cnt_clr,
    output stall_pc, stall_id, stall_exmem, bubble_ex, flush_id, state,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes and load-use bubbles,
// with a sticky memory-timeout flag and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic           clk,
  input logic           reset_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLu    = 2'd1,
    StFlush = 2'd2,
    StMwait = 2'd3
  } state_e;

  localparam logic [1:0] FlushRem   = 2'(FLUSH_CYCLES - 1);
  localparam bit         MultiFlush = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d, eff_state;
  logic        ret_flush_q, ret_flush_d;
  logic [1:0]  rem_q, rem_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic mem_hold;
  logic load_use;
  logic rs1_hit, rs2_hit;
  logic stall_pc_c, stall_id_c, stall_exmem_c, bubble_ex_c, flush_id_c;
  logic flush_inc;
  logic stall_pc_g;

  assign mem_hold = hz.d_req_MEM & ~hz.d_ready;
  assign rs1_hit  = hz.rs1_used_ID & (hz.Rs1_ID == hz.Rd_EX);
  assign rs2_hit  = hz.rs2_used_ID & (hz.Rs2_ID == hz.Rd_EX);
  assign load_use = hz.d_load_enable_EX & (hz.Rd_EX != 5'd0) & (rs1_hit | rs2_hit);

  // The cycle the memory access completes is decided by the state MWAIT was entered from,
  // so a pending flush or load-use hazard is handled without losing a cycle.
  always_comb begin
    eff_state = state_q;
    if (state_q == StMwait) begin
      eff_state = ret_flush_q ? StFlush : StRun;
    end
  end

  always_comb begin
    stall_pc_c    = 1'b0;
    stall_id_c    = 1'b0;
    stall_exmem_c = 1'b0;
    bubble_ex_c   = 1'b0;
    flush_id_c    = 1'b0;
    flush_inc     = 1'b0;
    state_d       = state_q;
    ret_flush_d   = ret_flush_q;
    rem_d         = rem_q;

    if (mem_hold) begin
      stall_pc_c    = 1'b1;
      stall_id_c    = 1'b1;
      stall_exmem_c = 1'b1;
      state_d       = StMwait;
      ret_flush_d   = (eff_state == StFlush);
    end else begin
      unique case (eff_state)
        StRun, StLu: begin
          if (hz.pc_taken_EX) begin
            flush_id_c = 1'b1;
            flush_inc  = 1'b1;
            if (MultiFlush) begin
              state_d = StFlush;
              rem_d   = FlushRem;
            end else begin
              state_d = StRun;
            end
          end else if ((eff_state == StRun) && load_use) begin
            stall_pc_c  = 1'b1;
            stall_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
            state_d     = StLu;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: begin
          flush_id_c = 1'b1;
          if (hz.pc_taken_EX) begin
            // A new taken branch counts this cycle as its first flush cycle.
            flush_inc = 1'b1;
            rem_d     = FlushRem;
            state_d   = StFlush;
          end else if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = StRun;
          end else begin
            rem_d   = rem_q - 2'd1;
            state_d = StFlush;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // Consecutive-wait counter and sticky timeout.
  always_comb begin
    wait_d    = 8'd0;
    timeout_d = timeout_q;
    if (mem_hold) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      if (32'(wait_d) >= TIMEOUT) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign stall_pc_g = reset_n & stall_pc_c;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (stall_pc_g && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StRun;
      ret_flush_q <= 1'b0;
      rem_q       <= 2'd0;
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ret_flush_q <= ret_flush_d;
      rem_q       <= rem_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls must act in the same cycle as the hazard, so they are decoded, not registered.
  assign hz.stall_pc    = stall_pc_g;
  assign hz.stall_id    = reset_n & stall_id_c;
  assign hz.stall_exmem = reset_n & stall_exmem_c;
  assign hz.bubble_ex   = reset_n & bubble_ex_c;
  assign hz.flush_id    = reset_n & flush_id_c;
  assign hz.state       = state_q;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
